divider_32_bit: RTL and testbench

//  Iterative restoring divider; the inverse of the datapath's 32-bit ripple adder.
//  It computes quotient and remainder by repeated shift-and-subtract, one bit per clock.
//  It serves MIPS DIV/DIVU in the ALU/HI-LO path: quotient goes to LO, remainder to HI.
//  It uses a start/busy/done handshake so the controller can stall while the divide runs.

---
 rtl/divider_32_bit.sv | 127 ++++++++++++
 tb/tb_divider_32_bit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/divider_32_bit.sv
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per clock,
// quotient to LO and remainder to HI, start/busy/done handshake.
module divider_32_bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // state | meaning
    // IDLE  | waiting for start
    // CALC  | one shift-and-subtract step per cycle, WIDTH cycles
    // FIX   | apply result signs and register the outputs
    // DONE  | done pulse; a new start is accepted here as in IDLE
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [5:0] CNT_INIT = 6'(WIDTH);

    state_t           r_state;
    logic [5:0]       r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_divisor;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dbz;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic             w_trial_neg;

    // |MIN| wraps to MIN, which is the correct magnitude read as unsigned
    assign w_a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign w_b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
    assign w_rem_sh    = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial     = w_rem_sh - {1'b0, r_divisor};
    assign w_trial_neg = w_trial[WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_rem         <= '0;
            r_dvd         <= '0;
            r_divisor     <= '0;
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
            r_dbz         <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_dvd     <= w_a_mag;
                        r_divisor <= w_b_mag;
                        r_q_neg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_r_neg   <= signed_op & a[WIDTH-1];
                        r_dbz     <= (b == '0);
                        r_rem     <= '0;
                        r_cnt     <= CNT_INIT;
                        r_busy    <= 1'b1;
                        r_state   <= S_CALC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_rem <= w_trial_neg ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_dvd <= {r_dvd[WIDTH-2:0], ~w_trial_neg};
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // remainder sign fix alone restores the original a when b==0
                    if (r_dbz) begin
                        r_quotient <= '1;
                    end else begin
                        r_quotient <= r_q_neg ? -r_dvd : r_dvd;
                    end
                    r_remainder   <= r_r_neg ? -r_rem : r_rem;
                    r_div_by_zero <= r_dbz;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b1;
                    r_state       <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_divider_32_bit.sv
// Directed and random checks of divider_32_bit against a behavioural model,
// with a scoreboard queue of expected results.
module tb_divider_32_bit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    exp_t        sb[$];
    int          total  = 0;
    int          passed = 0;
    logic [31:0] last_q = '0;

    divider_32_bit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .signed_op  (signed_op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input bit s, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        if (y == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = x;
            e.dbz = 1'b1;
        end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
            e.dbz = 1'b0;
        end else if (s) begin
            e.q = 32'($signed(x) / $signed(y));
            e.r = 32'($signed(x) % $signed(y));
            e.dbz = 1'b0;
        end else begin
            e.q = x / y;
            e.r = x % y;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // drive a request; when now_edge is 0, first move to the next falling edge
    task automatic issue(input bit now_edge, input bit s, input logic [31:0] x, input logic [31:0] y);
        if (!now_edge) @(negedge clk);
        start     = 1'b1;
        signed_op = s;
        a         = x;
        b         = y;
        sb.push_back(model(s, x, y));
    endtask

    // called at the falling edge where start is driven; returns at the falling edge showing done
    task automatic wait_done(input string tag, input bit glitch);
        int   lat = 1;
        int   bc  = 0;
        exp_t e;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
        chk({tag, "_q_held"}, quotient, last_q);
        while (!done && lat < 200) begin
            if (busy) bc++;
            if (glitch && lat == 5) begin
                start = 1'b1; signed_op = 1'b1; a = 32'h0000_DEAD; b = 32'd3;
            end else if (glitch && lat == 6) begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'd34);
        chk({tag, "_busy_cycles"}, 32'(bc), 32'd33);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_q"}, quotient, e.q);
            chk({tag, "_r"}, remainder, e.r);
            chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
            last_q = e.q;
        end else begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        reset_n = 1'b1;

        issue(0, 0, 32'd100, 32'd7);                 wait_done("divu_100_7", 0);
        chk("divu_100_7_const_q", quotient, 32'd14);
        chk("divu_100_7_const_r", remainder, 32'd2);
        issue(0, 1, 32'hFFFF_FFF9, 32'd2);           wait_done("div_m7_2", 0);
        chk("div_m7_2_const_q", quotient, 32'hFFFF_FFFD);
        chk("div_m7_2_const_r", remainder, 32'hFFFF_FFFF);
        issue(0, 1, 32'd7, 32'hFFFF_FFFE);           wait_done("div_7_m2", 0);
        issue(0, 1, 32'd5, 32'd0);                   wait_done("div_5_0", 0);
        issue(0, 0, 32'd5, 32'd0);                   wait_done("divu_5_0", 0);
        issue(0, 1, 32'hFFFF_FFF9, 32'd0);           wait_done("div_m7_0", 0);
        issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done("div_min_m1", 0);
        issue(0, 0, 32'hFFFF_FFFF, 32'd1);           wait_done("divu_max_1", 0);
        issue(0, 1, 32'h8000_0000, 32'd7);           wait_done("div_min_7", 0);

        issue(0, 0, 32'd99, 32'd9);                  wait_done("ignore_start", 1);
        chk("ignore_start_const_q", quotient, 32'd11);
        issue(1, 1, 32'hFFFF_FF9C, 32'd7);           wait_done("back2back", 0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            issue(0, i[0], x, y);
            wait_done($sformatf("rand%0d", i), 0);
        end

        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; a = 32'd12345; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_q", quotient, 32'd0);
        chk("midrst_r", remainder, 32'd0);
        chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        last_q = '0;
        @(negedge clk);
        reset_n = 1'b1;
        issue(0, 0, 32'd1000, 32'd10);               wait_done("after_rst", 0);
        chk("after_rst_const_q", quotient, 32'd100);

        @(negedge clk);
        chk("idle_done_low", {31'd0, done}, 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
